// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

   // Controller states: waiting for operands, shifting bits, holding result.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } ssub_state_t;

   // A subtraction starts with no incoming borrow.
   localparam logic BORROW_RST = 1'b0;

endpackage

// File: rtl/full_subtractor_cell.sv
// One-bit full subtractor: d = a - b - bin, bout set when the bit underflows.
module full_subtractor_cell (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   // Difference bit and borrow toward the next more significant bit.
   always_comb begin
      d    = a ^ b ^ bin;
      bout = (~a & b) | (~(a ^ b) & bin);
   end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one bit per clock through a single subtractor cell.
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
   output logic             busy
);

   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   ssub_state_t      state_q, state_d;
   logic [WIDTH-1:0] a_sh, b_sh, diff_sh;
   logic             borrow_q;
   logic [CNT_W-1:0] cnt;
   logic             cell_d, cell_bout;
   logic             accept, last_bit;

   assign accept   = (state_q == IDLE) && in_valid;
   assign last_bit = (cnt == LAST_BIT);

   full_subtractor_cell u_cell (
      .a    (a_sh[0]),
      .b    (b_sh[0]),
      .bin  (borrow_q),
      .d    (cell_d),
      .bout (cell_bout)
   );

   // State register; reset discards any in-flight operation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decode.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (in_valid) state_d = RUN;
         RUN:     if (last_bit) state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs come only from registered state and datapath registers.
   always_comb begin
      in_ready   = (state_q == IDLE);
      out_valid  = (state_q == DONE);
      busy       = (state_q != IDLE);
      diff       = diff_sh;
      borrow_out = borrow_q;
   end

   // Datapath: load operands on accept, then shift one bit per RUN cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sh     <= '0;
         b_sh     <= '0;
         diff_sh  <= '0;
         borrow_q <= BORROW_RST;
         cnt      <= '0;
      end else if (accept) begin
         a_sh     <= a;
         b_sh     <= b;
         diff_sh  <= '0;
         borrow_q <= BORROW_RST;
         cnt      <= '0;
      end else if (state_q == RUN) begin
         a_sh     <= a_sh >> 1;
         b_sh     <= b_sh >> 1;
         // Result bits enter at the MSB so bit 0 lands at position 0 after WIDTH shifts.
         diff_sh  <= {cell_d, diff_sh[WIDTH-1:1]};
         borrow_q <= cell_bout;
         cnt      <= cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized and directed bench for serial_subtractor at WIDTH=8 and WIDTH=16.
module tb_serial_subtractor;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [15:0] a_in, b_in;
   logic        out_ready;
   int          sel;
   int          n_tests = 0;
   int          n_fail  = 0;

   logic        iv8, or8, ir8, ov8, bo8, busy8;
   logic [7:0]  d8;
   logic        iv16, or16, ir16, ov16, bo16, busy16;
   logic [15:0] d16;
   logic        s_ir, s_ov, s_bo, s_busy;
   logic [15:0] s_diff;

   always #5 clk = ~clk;

   assign iv8  = in_valid && (sel == 8);
   assign or8  = out_ready && (sel == 8);
   assign iv16 = in_valid && (sel == 16);
   assign or16 = out_ready && (sel == 16);

   assign s_ir   = (sel == 16) ? ir16 : ir8;
   assign s_ov   = (sel == 16) ? ov16 : ov8;
   assign s_bo   = (sel == 16) ? bo16 : bo8;
   assign s_busy = (sel == 16) ? busy16 : busy8;
   assign s_diff = (sel == 16) ? d16 : {8'h00, d8};

   serial_subtractor #(.WIDTH(8)) dut8 (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (iv8),
      .in_ready   (ir8),
      .a          (a_in[7:0]),
      .b          (b_in[7:0]),
      .out_valid  (ov8),
      .out_ready  (or8),
      .diff       (d8),
      .borrow_out (bo8),
      .busy       (busy8)
   );

   serial_subtractor #(.WIDTH(16)) dut16 (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (iv16),
      .in_ready   (ir16),
      .a          (a_in),
      .b          (b_in),
      .out_valid  (ov16),
      .out_ready  (or16),
      .diff       (d16),
      .borrow_out (bo16),
      .busy       (busy16)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One full transaction: accept, wait for result, optional stall, transfer.
   task automatic do_op(input int w, input logic [15:0] av, input logic [15:0] bv,
                        input int stall, input bit hold);
      logic [15:0] mask;
      logic [15:0] exp_d;
      logic        exp_b;
      int          k;
      int          lat;
      mask  = (w == 16) ? 16'hFFFF : 16'h00FF;
      exp_d = (av - bv) & mask;
      exp_b = ((av & mask) < (bv & mask));
      sel       = w;
      out_ready = 1'b0;
      k = 0;
      while (!s_ir && k < 50) begin
         @(posedge clk); #1;
         k++;
      end
      check_eq("ready_before_accept", {31'd0, s_ir}, 32'd1);
      a_in     = av;
      b_in     = bv;
      in_valid = 1'b1;
      @(posedge clk); #1;
      check_eq("busy_after_accept", {31'd0, s_busy}, 32'd1);
      check_eq("ready_low_in_run", {31'd0, s_ir}, 32'd0);
      if (!hold) in_valid = 1'b0;
      lat = 0;
      while (!s_ov && lat < 100) begin
         if (hold) begin
            a_in = 16'($urandom);
            b_in = 16'($urandom);
         end
         @(posedge clk); #1;
         lat++;
      end
      in_valid = 1'b0;
      check_eq("latency", lat, w);
      for (int s = 0; s < stall; s++) begin
         check_eq("stall_valid", {31'd0, s_ov}, 32'd1);
         check_eq("stall_diff", {16'd0, s_diff}, {16'd0, exp_d});
         check_eq("stall_borrow", {31'd0, s_bo}, {31'd0, exp_b});
         @(posedge clk); #1;
      end
      check_eq("out_valid", {31'd0, s_ov}, 32'd1);
      check_eq("diff", {16'd0, s_diff}, {16'd0, exp_d});
      check_eq("borrow_out", {31'd0, s_bo}, {31'd0, exp_b});
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check_eq("valid_after_xfer", {31'd0, s_ov}, 32'd0);
      check_eq("ready_after_xfer", {31'd0, s_ir}, 32'd1);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      a_in      = '0;
      b_in      = '0;
      out_ready = 1'b0;
      sel       = 8;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_ready8", {31'd0, ir8}, 32'd1);
      check_eq("rst_valid8", {31'd0, ov8}, 32'd0);
      check_eq("rst_diff8", {24'd0, d8}, 32'd0);
      check_eq("rst_borrow8", {31'd0, bo8}, 32'd0);
      check_eq("rst_busy8", {31'd0, busy8}, 32'd0);
      check_eq("rst_ready16", {31'd0, ir16}, 32'd1);
      check_eq("rst_valid16", {31'd0, ov16}, 32'd0);
      check_eq("rst_diff16", {16'd0, d16}, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Directed vectors.
      do_op(8, 16'h05, 16'h03, 0, 1'b0);
      do_op(8, 16'h03, 16'h05, 0, 1'b0);
      do_op(8, 16'h00, 16'h01, 0, 1'b0);
      do_op(8, 16'hFF, 16'hFF, 0, 1'b0);
      // Backpressure for 5 cycles.
      do_op(8, 16'h9C, 16'h3A, 5, 1'b0);
      // in_valid held with changing operands during RUN.
      do_op(8, 16'h41, 16'hC7, 0, 1'b1);

      // Asynchronous reset in RUN cycle 4.
      sel      = 8;
      a_in     = 16'h55;
      b_in     = 16'h22;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("busy_before_rst", {31'd0, busy8}, 32'd1);
      #2 rst = 1'b1;
      #1;
      check_eq("mid_rst_ready", {31'd0, ir8}, 32'd1);
      check_eq("mid_rst_valid", {31'd0, ov8}, 32'd0);
      check_eq("mid_rst_busy", {31'd0, busy8}, 32'd0);
      check_eq("mid_rst_diff", {24'd0, d8}, 32'd0);
      check_eq("mid_rst_borrow", {31'd0, bo8}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      do_op(8, 16'h80, 16'h01, 0, 1'b0);

      // Randomized back-to-back operations.
      for (int i = 0; i < 150; i++) begin
         do_op(8, 16'($urandom_range(255)), 16'($urandom_range(255)),
               ($urandom_range(3) == 0) ? int'($urandom_range(3)) : 0,
               ($urandom_range(7) == 0));
      end
      for (int i = 0; i < 100; i++) begin
         do_op(16, 16'($urandom), 16'($urandom),
               ($urandom_range(3) == 0) ? int'($urandom_range(3)) : 0,
               ($urandom_range(7) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
